// File: rtl/ndro_pulse_driver.sv
// ndro_pulse_driver: turns a SET/RESET/CLK/NOP command stream into toggle-encoded pulse lines
// for an RSFQ NDRO cell, with timing guards and a shadow cell model. Option macro: NDRO_DRV_GUARD_EN.
module ndro_pulse_driver #(
  parameter int GAP_W       = 8,
  parameter int CNT_W       = 16,
  parameter int RST_SET_CYC = 3,
  parameter int CLK_RST_CYC = 4,
  parameter int CLK_CLK_CYC = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [GAP_W-1:0] cmd_gap,
  output logic             set_o,
  output logic             reset_o,
  output logic             clk_o,
  output logic             exp_state,
  output logic             exp_out,
  output logic [CNT_W-1:0] out_cnt,
  output logic             busy,
  output logic             viol
);

  typedef enum logic [1:0] {
    OP_SET = 2'd0,
    OP_RST = 2'd1,
    OP_CLK = 2'd2,
    OP_NOP = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GUARD = 2'd1,
    S_FIRE  = 2'd2,
    S_GAP   = 2'd3
  } state_e;

  localparam int GRD_N  = 3;
  localparam int GMAX_A = (RST_SET_CYC > CLK_RST_CYC) ? RST_SET_CYC : CLK_RST_CYC;
  localparam int GMAX   = (GMAX_A > CLK_CLK_CYC) ? GMAX_A : CLK_CLK_CYC;
  localparam int GRD_W  = (GMAX > 2) ? $clog2(GMAX) : 1;

  // A guard loaded with N-1 at the guarding pulse reaches 0 in the cycle ahead of
  // edge +N, so the guarded pulse can land no earlier than N edges later.
  function automatic logic [GRD_W-1:0] guard_load(input int idx);
    int n;
    n = (idx == 0) ? RST_SET_CYC : (idx == 1) ? CLK_RST_CYC : CLK_CLK_CYC;
    return (n > 0) ? GRD_W'(n - 1) : '0;
  endfunction

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             set_line_q, set_line_d;
  logic             rst_line_q, rst_line_d;
  logic             clk_line_q, clk_line_d;
  logic             exp_state_q, exp_state_d;
  logic             exp_out_q, exp_out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             viol_q, viol_d;

  // Guard index matches the op it holds off: 0 = g_set, 1 = g_rst, 2 = g_clk.
  logic [GRD_N-1:0] g_ld;
  logic [GRD_N-1:0] g_cur_zero;
  logic [GRD_N-1:0] g_nxt_zero;
  logic [3:0]       cur_clear_v;
  logic [3:0]       nxt_clear_v;
  logic [1:0]       sel_op;
  logic             may_fire;
  logic             hit_viol;
  logic             accept;

  genvar gi;
  generate
    for (gi = 0; gi < GRD_N; gi++) begin : g_guard
      localparam logic [GRD_W-1:0] LD_VAL = guard_load(gi);
      logic [GRD_W-1:0] grd_q, grd_d, grd_dec;

      always_comb begin
        grd_dec = (grd_q == '0) ? '0 : grd_q - 1'b1;
        grd_d   = g_ld[gi] ? LD_VAL : grd_dec;
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          grd_q <= '0;
        end else begin
          grd_q <= grd_d;
        end
      end

      assign g_cur_zero[gi] = (grd_q == '0);
      assign g_nxt_zero[gi] = (grd_dec == '0);
    end
  endgenerate

  // NOP has no guard, so its slot is permanently clear.
  assign cur_clear_v = {1'b1, g_cur_zero};
  assign nxt_clear_v = {1'b1, g_nxt_zero};

  assign sel_op    = (state_q == S_IDLE) ? cmd_op : op_q;
  assign cmd_ready = (state_q == S_IDLE) && !reset;
  assign accept    = cmd_valid && cmd_ready;

`ifdef NDRO_DRV_GUARD_EN
  assign may_fire = nxt_clear_v[sel_op];
  assign hit_viol = 1'b0;
`else
  assign may_fire = 1'b1;
  assign hit_viol = (state_q == S_FIRE) && !cur_clear_v[op_q];
`endif

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    gap_d       = gap_q;
    set_line_d  = set_line_q;
    rst_line_d  = rst_line_q;
    clk_line_d  = clk_line_q;
    exp_state_d = exp_state_q;
    exp_out_d   = exp_out_q;
    cnt_d       = cnt_q;
    viol_d      = viol_q | hit_viol;
    g_ld        = '0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d    = op_e'(cmd_op);
          gap_d   = cmd_gap;
          state_d = may_fire ? S_FIRE : S_GUARD;
        end
      end

      S_GUARD: begin
        if (may_fire) begin
          state_d = S_FIRE;
        end
      end

      S_FIRE: begin
        case (op_q)
          OP_SET: begin
            set_line_d  = ~set_line_q;
            exp_state_d = 1'b1;
          end
          OP_RST: begin
            rst_line_d  = ~rst_line_q;
            exp_state_d = 1'b0;
            g_ld[0]     = 1'b1;
          end
          OP_CLK: begin
            clk_line_d = ~clk_line_q;
            // Only a clock read of a stored 1 produces an output pulse.
            if (exp_state_q) begin
              exp_out_d = ~exp_out_q;
              cnt_d     = cnt_q + 1'b1;
              g_ld[1]   = 1'b1;
              g_ld[2]   = 1'b1;
            end
          end
          default: begin
          end
        endcase
        state_d = (gap_q == '0) ? S_IDLE : S_GAP;
      end

      S_GAP: begin
        gap_d = gap_q - 1'b1;
        if (gap_q == GAP_W'(1)) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= OP_NOP;
      gap_q       <= '0;
      set_line_q  <= 1'b0;
      rst_line_q  <= 1'b0;
      clk_line_q  <= 1'b0;
      exp_state_q <= 1'b0;
      exp_out_q   <= 1'b0;
      cnt_q       <= '0;
      viol_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      gap_q       <= gap_d;
      set_line_q  <= set_line_d;
      rst_line_q  <= rst_line_d;
      clk_line_q  <= clk_line_d;
      exp_state_q <= exp_state_d;
      exp_out_q   <= exp_out_d;
      cnt_q       <= cnt_d;
      viol_q      <= viol_d;
    end
  end

  assign set_o     = set_line_q;
  assign reset_o   = rst_line_q;
  assign clk_o     = clk_line_q;
  assign exp_state = exp_state_q;
  assign exp_out   = exp_out_q;
  assign out_cnt   = cnt_q;
  assign busy      = (state_q != S_IDLE);
  assign viol      = viol_q;

endmodule

// File: tb/tb_ndro_pulse_driver.sv
// tb_ndro_pulse_driver: directed plus random command stream against an edge-time reference model
// of the NDRO pulse driver (pulse edges, stalls, shadow state, counter wrap, violations, resets).
module tb_ndro_pulse_driver;

  localparam int GAP_W       = 8;
  localparam int CNT_W       = 4;
  localparam int RST_SET_CYC = 3;
  localparam int CLK_RST_CYC = 4;
  localparam int CLK_CLK_CYC = 8;
  localparam int NEVER       = -100000;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [GAP_W-1:0] cmd_gap;
  logic             set_o, reset_o, clk_o;
  logic             exp_state, exp_out;
  logic [CNT_W-1:0] out_cnt;
  logic             busy, viol;

  ndro_pulse_driver #(
    .GAP_W(GAP_W), .CNT_W(CNT_W), .RST_SET_CYC(RST_SET_CYC),
    .CLK_RST_CYC(CLK_RST_CYC), .CLK_CLK_CYC(CLK_CLK_CYC)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_gap(cmd_gap), .set_o(set_o), .reset_o(reset_o),
    .clk_o(clk_o), .exp_state(exp_state), .exp_out(exp_out), .out_cnt(out_cnt),
    .busy(busy), .viol(viol)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int n_txn = 0;

  // Model: pulse edges are tracked as absolute edge numbers.
  bit m_pend, m_set, m_rst, m_clk, m_state, m_out, m_viol;
  int m_cnt, m_op, m_fire_at, m_idle_from, last_rst, last_clk1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int earliest_edge(input int op);
    case (op)
      0:       return last_rst + RST_SET_CYC;
      1:       return last_clk1 + CLK_RST_CYC;
      2:       return last_clk1 + CLK_CLK_CYC;
      default: return NEVER;
    endcase
  endfunction

  task automatic model_reset();
    m_pend = 0; m_set = 0; m_rst = 0; m_clk = 0;
    m_state = 0; m_out = 0; m_viol = 0; m_cnt = 0;
    last_rst = NEVER; last_clk1 = NEVER;
    m_idle_from = cyc;
  endtask

  task automatic model_fire();
    if (cyc < earliest_edge(m_op)) m_viol = 1;
    case (m_op)
      0: begin m_set = !m_set; m_state = 1; end
      1: begin m_rst = !m_rst; m_state = 0; last_rst = cyc; end
      2: begin
        m_clk = !m_clk;
        if (m_state) begin
          m_out = !m_out;
          m_cnt = (m_cnt + 1) % (1 << CNT_W);
          last_clk1 = cyc;
        end
      end
      default: ;
    endcase
    m_pend = 0;
  endtask

  task automatic model_accept(input int op, input int gap);
    int fire_at;
    fire_at = cyc + 1;
`ifdef NDRO_DRV_GUARD_EN
    if (earliest_edge(op) > fire_at) fire_at = earliest_edge(op);
`endif
    m_op = op;
    m_pend = 1;
    m_fire_at = fire_at;
    m_idle_from = fire_at + gap;
  endtask

  // One clock cycle: drive, compare every output against the model, advance one edge.
  task automatic tick(input bit rst, input bit v, input int op, input int gap, output bit acc);
    bit exp_ready;
    reset = rst;
    cmd_valid = v;
    cmd_op = 2'(op);
    cmd_gap = GAP_W'(gap);
    #1;
    exp_ready = !rst && (cyc >= m_idle_from);
    check_val("cmd_ready", cmd_ready, exp_ready);
    check_val("busy", busy, (cyc < m_idle_from));
    check_val("set_o", set_o, m_set);
    check_val("reset_o", reset_o, m_rst);
    check_val("clk_o", clk_o, m_clk);
    check_val("exp_state", exp_state, m_state);
    check_val("exp_out", exp_out, m_out);
    check_val("out_cnt", out_cnt, m_cnt);
    check_val("viol", viol, m_viol);
    acc = v && exp_ready;
    @(posedge clk);
    cyc++;
    #1;
    if (rst) begin
      model_reset();
    end else begin
      if (m_pend && cyc == m_fire_at) model_fire();
      if (acc) model_accept(op, gap);
    end
  endtask

  task automatic send(input int op, input int gap);
    bit acc;
    int n;
    acc = 0;
    n = 0;
    while (!acc && n < 600) begin
      tick(0, 1, op, gap, acc);
      n++;
    end
    if (!acc) check_val("accept_timeout", n, 0);
    else begin
      n_txn++;
      $display("txn %0d: op=%0d gap=%0d accepted at edge %0d", n_txn, op, gap, cyc);
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) tick(0, 0, $urandom_range(0, 3), $urandom_range(0, 5), acc);
  endtask

  task automatic pulse_reset(input bit with_valid);
    bit acc;
    tick(1, with_valid, $urandom_range(0, 3), 0, acc);
    $display("txn reset pulse at edge %0d", cyc);
  endtask

  initial begin
    bit acc;
    int op, gap;
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = '0;
    cmd_gap = '0;
    repeat (2) @(posedge clk);
    #1;
    cyc = 0;
    model_reset();

    // Reset state, then SET and CLK with no gap.
    idle(2);
    send(0, 0); send(2, 0); idle(3);
    // Back-to-back state-1 clocks: guarded spacing or violation.
    send(2, 0); send(2, 0); idle(10);
    // State-0 clocks: natural spacing, no output.
    send(1, 0); send(2, 0); send(2, 0); idle(3);
    // RESET then SET.
    send(1, 0); send(0, 0); idle(4);
    // CLK then RESET in state 1, then clear via reset.
    send(2, 0); send(1, 0); idle(3);
    pulse_reset(1); idle(2);
    // Long gap aborted by a reset ten cycles after accept.
    send(0, 0); send(2, 200); idle(9);
    pulse_reset(0); idle(3);
    // Maximum gap and counter wrap through many state-1 clocks.
    send(3, 255); idle(1);
    send(0, 0);
    for (int i = 0; i < 18; i++) send(2, $urandom_range(0, 1));
    idle(4);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        pulse_reset($urandom_range(0, 1));
      end else begin
        op = $urandom_range(0, 3);
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4, 5: gap = 0;
          6, 7, 8:          gap = $urandom_range(1, 6);
          default:          gap = $urandom_range(0, 40);
        endcase
        send(op, gap);
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      end
    end
    idle(10);
    tick(1, 1, 2, 0, acc);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
